cmd_uart_link: RTL
==================

CMD_UART_LINK -- requirements
Module: cmd_uart_link

Interface
- REQ-001: Parameter BAUD_DIV, default 2604, is the number of clk cycles per UART bit (19200 baud at 50 MHz).
- REQ-002: clk  input  1  system clock; all state is updated on the rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: RX  input  1  serial command line from the remote; idles high; asynchronous to clk.
- REQ-005: TX  output  1  serial response line to the remote; idles high.
- REQ-006: cmd  output  16  assembled command; first received byte is cmd[15:8], second is cmd[7:0].
- REQ-007: cmd_rdy  output  1  a complete 16-bit command is valid on cmd.
- REQ-008: clr_cmd_rdy  input  1  single-cycle pulse from the consumer that acknowledges cmd.
- REQ-009: resp  input  8  response byte to transmit (0xA5 is a positive ack).
- REQ-010: trmt  input  1  single-cycle pulse that starts transmission of resp.
- REQ-011: tx_done  output  1  the last requested response byte has been fully sent.

Function
- REQ-012: RX SHALL pass through two flops that preset to 1 before any use.
- REQ-013: Receiver FSM SHALL have states IDLE and RECV; IDLE->RECV on a synchronized RX low.
- REQ-014: On start detection the baud counter SHALL load BAUD_DIV/2 (1302); subsequent samples SHALL follow every BAUD_DIV cycles.
- REQ-015: The receiver SHALL sample 10 bits (start, 8 data LSB-first, stop), then return to IDLE.
- REQ-016: A sampled start bit of 1 (glitch) SHALL abort to IDLE with no byte delivered.
- REQ-017: A sampled stop bit of 0 SHALL discard the byte; assembler state is unchanged.
- REQ-018: Assembler FSM SHALL have states WAIT_HI and WAIT_LO.
  - WAIT_HI: a valid byte is stored as the high byte, cmd_rdy is cleared, and the FSM moves to WAIT_LO.
  - WAIT_LO: a valid byte completes cmd, cmd_rdy is set in the cycle after the stop-bit sample, and the FSM returns to WAIT_HI.
- REQ-019: cmd SHALL remain stable from the assertion of cmd_rdy until the next high byte is stored.
- REQ-020: clr_cmd_rdy SHALL clear cmd_rdy on the next edge.
- REQ-021: If clr_cmd_rdy coincides with the setting of cmd_rdy, the set SHALL win.
- REQ-022: If no valid byte arrives within 2^20 clk cycles while in WAIT_LO, the assembler SHALL return to WAIT_HI and discard the high byte.
- REQ-023: Transmitter FSM SHALL have states IDLE and XMIT.
  - trmt in IDLE loads {1'b1, resp, 1'b0} into a shift register, clears tx_done, and enters XMIT.
  - TX drives the shift register LSB, which shifts once every BAUD_DIV cycles.
  - After 10 bit periods the transmitter sets tx_done and returns to IDLE.
- REQ-024: trmt received while in XMIT SHALL be ignored; the transmission in progress is unaffected.
- REQ-025: Receive and transmit paths SHALL operate fully independently (full duplex).
- REQ-026: Latency from the RX stop-bit sample to cmd_rdy SHALL be exactly 1 cycle; from trmt to the TX start bit, exactly 1 cycle.

Reset
- REQ-027: Reset SHALL immediately force the following:
  - both FSMs to IDLE and the assembler to WAIT_HI;
  - cmd = 0x0000, cmd_rdy = 0;
  - TX = 1, tx_done = 0;
  - sync flops = 1;
  - all counters = 0.
- REQ-028: Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a new falling edge on RX.

Verification
- REQ-029: Bytes 0x57 then 0xF4 sent back-to-back -> cmd = 0x57F4, cmd_rdy high for exactly one window, cleared 1 cycle after the clr_cmd_rdy pulse.
- REQ-030: trmt with resp = 0xA5 -> TX bit pattern 0,1,0,1,0,0,1,0,1,1 at 2604-cycle spacing; tx_done rises 26040 cycles after the start bit.
- REQ-031: 0x50 sent, then idle for 2^20+10 cycles, then 0x5B and 0xF4 -> cmd = 0x5BF4.
- REQ-032: RX low pulse of 500 cycles -> no byte delivered, assembler still in WAIT_HI; the following bytes 0x53,0xF4 -> cmd = 0x53F4.
- REQ-033: Frame 0x04 with stop bit forced 0, then 0x50,0x04 -> cmd = 0x5004; the bad byte is ignored.
- REQ-034: rst_n pulsed low during bit 4 of a high byte -> cmd_rdy = 0 and TX = 1 immediately; the next full pair 0x12,0x34 -> cmd = 0x1234.

Source files
------------

// File: rtl/cmd_uart_link_if.sv
// ---------------------------------------------------------------------------
// cmd_uart_link_if
//   Parallel-side interface of the command UART link: the assembled 16-bit
//   command with its ready/acknowledge pair, and the response byte with its
//   transmit strobe and done flag.
//
//   Signals
//     cmd          [15:0] assembled command (first byte in [15:8])
//     cmd_rdy             cmd holds a complete command
//     clr_cmd_rdy         single-cycle acknowledge of cmd from the consumer
//     resp         [7:0]  response byte to send
//     trmt                single-cycle strobe that starts sending resp
//     tx_done             the last requested response byte has been sent
//
//   Modports
//     master : the consumer of commands / producer of responses
//     slave  : the link itself (cmd_uart_link)
// ---------------------------------------------------------------------------
interface cmd_uart_link_if;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        trmt;
   logic        tx_done;

   modport master (
      input  cmd, cmd_rdy, tx_done,
      output clr_cmd_rdy, resp, trmt
   );

   modport slave (
      output cmd, cmd_rdy, tx_done,
      input  clr_cmd_rdy, resp, trmt
   );
endinterface

// File: rtl/cmd_uart_link.sv
// ---------------------------------------------------------------------------
// cmd_uart_link
//   Full-duplex 8N1 UART link. The receive path assembles two bytes into a
//   16-bit command (high byte first); the transmit path sends one response
//   byte per trmt strobe. Both paths run independently.
//
//   Parameters
//     BAUD_DIV  clk cycles per UART bit (2604 = 19200 baud at 50 MHz)
//     TMO_W     the assembler abandons a lone high byte after 2**TMO_W
//               cycles without a low byte
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     RX     serial command line, idles high, asynchronous to clk
//     TX     serial response line, idles high
//     link   cmd_uart_link_if.slave (cmd, cmd_rdy, clr_cmd_rdy, resp,
//            trmt, tx_done)
// ---------------------------------------------------------------------------
module cmd_uart_link #(
   parameter int BAUD_DIV = 2604,
   parameter int TMO_W    = 20
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           RX,
   output logic           TX,
   cmd_uart_link_if.slave link
);

   localparam int                BAUD_W    = $clog2(BAUD_DIV);
   localparam logic [BAUD_W-1:0] HALF_BIT  = BAUD_W'(BAUD_DIV / 2);
   localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(BAUD_DIV - 1);

   typedef enum logic {RX_IDLE, RX_RECV}         rx_state_t;
   typedef enum logic {ASM_WAIT_HI, ASM_WAIT_LO} asm_state_t;
   typedef enum logic {TX_IDLE, TX_XMIT}         tx_state_t;

   // ------------------------------------------------------------------------
   // RX synchronizer and line-idle qualifier
   // ------------------------------------------------------------------------
   logic       rx_meta;
   logic       rx_sync;
   logic [1:0] rx_high_cnt;
   logic       rx_armed;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value of its inputs regardless of process ordering.
   // NOTE: the synchronizer presets to 1 (line idle) so reset never looks
   // like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
      end
   end

   // A start is only accepted after the line has been seen high for three
   // consecutive cycles. The preset synchronizer shows "high" for at most two
   // cycles after reset, so a line that is still low mid-frame when reset
   // releases cannot start a bogus frame; a genuine falling edge is required.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   rx_high_cnt <= '0;
      else if (!rx_sync)            rx_high_cnt <= '0;
      else if (rx_high_cnt != 2'd3) rx_high_cnt <= rx_high_cnt + 2'd1;
   end

   assign rx_armed = (rx_high_cnt == 2'd3);

   // ------------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------------
   rx_state_t         rx_state, rx_next;
   logic [BAUD_W-1:0] rx_baud_cnt;
   logic [3:0]        rx_bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]        rx_shift;
   logic              rx_start, rx_sample, rx_abort, rx_last, byte_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: if (rx_start)            rx_next = RX_RECV;
         RX_RECV: if (rx_abort || rx_last) rx_next = RX_IDLE;
         default:                          rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_start  = 1'b0;
      rx_sample = 1'b0;
      rx_abort  = 1'b0;
      rx_last   = 1'b0;
      byte_vld  = 1'b0;
      case (rx_state)
         RX_IDLE: rx_start = rx_armed && !rx_sync;
         RX_RECV: begin
            rx_sample = (rx_baud_cnt == '0);
            // Start bit read back high: it was a glitch, not a frame.
            rx_abort  = rx_sample && (rx_bit_cnt == 4'd0) && rx_sync;
            rx_last   = rx_sample && (rx_bit_cnt == 4'd9);
            // A low stop bit is a framing error; the byte is dropped.
            byte_vld  = rx_last && rx_sync;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_baud_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_shift    <= '0;
      end else if (rx_start) begin
         // Half a bit lands the first sample mid-way through the start bit.
         rx_baud_cnt <= HALF_BIT;
         rx_bit_cnt  <= '0;
      end else if (rx_state == RX_RECV) begin
         if (rx_sample) begin
            rx_baud_cnt <= LAST_TICK;
            rx_bit_cnt  <= rx_bit_cnt + 4'd1;
            if (rx_bit_cnt != 4'd0 && rx_bit_cnt <= 4'd8)
               rx_shift <= {rx_sync, rx_shift[7:1]};   // LSB first
         end else begin
            rx_baud_cnt <= rx_baud_cnt - BAUD_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command assembler FSM
   // ------------------------------------------------------------------------
   asm_state_t       asm_state, asm_next;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       hi_byte;
   logic             store_hi, store_lo, asm_tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) asm_state <= ASM_WAIT_HI;
      else        asm_state <= asm_next;
   end

   always_comb begin
      asm_next = asm_state;
      case (asm_state)
         ASM_WAIT_HI: if (byte_vld)            asm_next = ASM_WAIT_LO;
         ASM_WAIT_LO: if (byte_vld || asm_tmo) asm_next = ASM_WAIT_HI;
         default:                              asm_next = ASM_WAIT_HI;
      endcase
   end

   always_comb begin
      store_hi = 1'b0;
      store_lo = 1'b0;
      asm_tmo  = 1'b0;
      case (asm_state)
         ASM_WAIT_HI: store_hi = byte_vld;
         ASM_WAIT_LO: begin
            store_lo = byte_vld;
            asm_tmo  = !byte_vld && (tmo_cnt == '1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt      <= '0;
         hi_byte      <= '0;
         link.cmd     <= '0;
         link.cmd_rdy <= 1'b0;
      end else begin
         // Counts cycles spent waiting for the low byte; wraps to 0 on timeout.
         if (asm_state == ASM_WAIT_LO && !store_lo) tmo_cnt <= tmo_cnt + TMO_W'(1);
         else                                       tmo_cnt <= '0;

         if (store_hi) hi_byte <= rx_shift;

         // cmd only changes as a whole, so it holds while cmd_rdy is high.
         if (store_lo) link.cmd <= {hi_byte, rx_shift};

         // Setting has priority over the consumer's acknowledge.
         if (store_lo)                          link.cmd_rdy <= 1'b1;
         else if (store_hi || link.clr_cmd_rdy) link.cmd_rdy <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Transmitter FSM
   // ------------------------------------------------------------------------
   tx_state_t         tx_state, tx_next;
   logic [BAUD_W-1:0] tx_baud_cnt;
   logic [3:0]        tx_bit_cnt;
   logic [9:0]        tx_shift;
   logic              tx_load, tx_tick, tx_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE: if (tx_load) tx_next = TX_XMIT;
         TX_XMIT: if (tx_end)  tx_next = TX_IDLE;
         default:              tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_load = 1'b0;
      tx_tick = 1'b0;
      tx_end  = 1'b0;
      case (tx_state)
         // trmt outside IDLE is ignored by construction.
         TX_IDLE: tx_load = link.trmt;
         TX_XMIT: begin
            tx_tick = (tx_baud_cnt == LAST_TICK);
            tx_end  = tx_tick && (tx_bit_cnt == 4'd9);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift     <= '1;   // line idles high
         tx_baud_cnt  <= '0;
         tx_bit_cnt   <= '0;
         link.tx_done <= 1'b0;
      end else begin
         if (tx_load) begin
            tx_shift    <= {1'b1, link.resp, 1'b0};
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
         end else if (tx_state == TX_XMIT) begin
            if (tx_tick) begin
               tx_baud_cnt <= '0;
               tx_bit_cnt  <= tx_bit_cnt + 4'd1;
               tx_shift    <= {1'b1, tx_shift[9:1]};
            end else begin
               tx_baud_cnt <= tx_baud_cnt + BAUD_W'(1);
            end
         end

         if (tx_load)     link.tx_done <= 1'b0;
         else if (tx_end) link.tx_done <= 1'b1;
      end
   end

   assign TX = tx_shift[0];

endmodule
